// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative multiply/divide unit owning the architectural HI/LO
// registers. MULT/MULTU produce a 64-bit product into {HI,LO}; DIV/DIVU
// produce quotient in LO and remainder in HI. Each runs 32 iterations plus
// one sign-fix cycle. MTHI/MTLO write A directly from IDLE.
//
// Ports:
//   clk      clock, rising edge
//   reset_n  async active-low reset (clears state, HI, LO, flags)
//   A, B     operands (rs, rt)
//   Op       0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   Start    request, sampled only in IDLE
//   Hi_out   HI register
//   Lo_out   LO register
//   Busy     iterative operation in flight
//   Done     one-cycle pulse after HI/LO take a MULT/DIV result
//   DivZero  qualifies Done: the divide had B == 0
module muldiv_hilo (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  Op,
  input  logic        Start,
  output logic [31:0] Hi_out,
  output logic [31:0] Lo_out,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero
);
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] opa;      // multiplicand (MUL) or divisor (DIV)
  logic [31:0] shreg;    // multiplier (MUL) or dividend/quotient (DIV)
  logic [63:0] acc;      // running product
  logic [32:0] rem;      // partial remainder, one spare bit for the borrow
  logic        sgn_q, sgn_r, op_div, dz;
  logic [31:0] hi, lo;
  logic        done, divzero;

  // Request decode
  logic        is_mul, is_div, is_signed;
  logic [31:0] abs_a, abs_b;
  assign is_mul    = (Op == OP_MULT) || (Op == OP_MULTU);
  assign is_div    = (Op == OP_DIV)  || (Op == OP_DIVU);
  assign is_signed = (Op == OP_MULT) || (Op == OP_DIV);
  assign abs_a     = (is_signed && A[31]) ? 32'd0 - A : A;
  assign abs_b     = (is_signed && B[31]) ? 32'd0 - B : B;

  // Shift-add step: add multiplicand into the upper half, then shift the
  // whole accumulator right so the next multiplier bit lines up.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, acc[63:32]} + {1'b0, (shreg[0] ? opa : 32'd0)};

  // Restoring step: bring in the next dividend bit and trial-subtract.
  // Bit 33 of the difference is the borrow; no borrow means quotient bit 1.
  logic [33:0] div_shift, div_diff;
  logic        qbit;
  assign div_shift = {rem, shreg[31]};
  assign div_diff  = div_shift - {2'b00, opa};
  assign qbit      = ~div_diff[33];

  // Sign fix-up values for the FIX cycle
  logic [63:0] prod_fix;
  logic [31:0] q_fix, r_fix;
  assign prod_fix = sgn_q ? 64'd0 - acc : acc;
  assign q_fix    = sgn_q ? 32'd0 - shreg : shreg;
  assign r_fix    = sgn_r ? 32'd0 - rem[31:0] : rem[31:0];

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (Start && is_mul)      state_nxt = S_MUL;
        else if (Start && is_div) state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (cnt == 5'd31) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. Busy spans the iterations and the FIX cycle.
  always_comb begin
    Busy    = (state != S_IDLE);
    Done    = done;
    DivZero = divzero;
    Hi_out  = hi;
    Lo_out  = lo;
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      opa     <= '0;
      shreg   <= '0;
      acc     <= '0;
      rem     <= '0;
      sgn_q   <= 1'b0;
      sgn_r   <= 1'b0;
      op_div  <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      divzero <= 1'b0;
    end else begin
      done    <= 1'b0;
      divzero <= 1'b0;
      case (state)
        S_IDLE: if (Start) begin
          if (Op == OP_MTHI) hi <= A;
          if (Op == OP_MTLO) lo <= A;
          if (is_mul || is_div) begin
            opa    <= is_mul ? abs_a : abs_b;
            shreg  <= is_mul ? abs_b : abs_a;
            sgn_q  <= is_signed & (A[31] ^ B[31]);
            sgn_r  <= is_signed & A[31];
            op_div <= is_div;
            dz     <= is_div && (B == 32'd0);
            acc    <= '0;
            rem    <= '0;
            cnt    <= '0;
          end
        end
        S_MUL: begin
          acc   <= {mul_sum, acc[31:1]};
          shreg <= {1'b0, shreg[31:1]};
          cnt   <= cnt + 5'd1;
        end
        S_DIV: begin
          rem   <= qbit ? div_diff[32:0] : div_shift[32:0];
          shreg <= {shreg[30:0], qbit};
          cnt   <= cnt + 5'd1;
        end
        S_FIX: begin
          if (op_div) begin
            lo <= q_fix;
            hi <= r_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          done    <= 1'b1;
          divzero <= dz;
          cnt     <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: stimulus pushes expected HI/LO/DivZero
// plus the accepting cycle; a monitor pops on every Done and also checks the
// 33-cycle latency. Unexpected Done pulses are flagged.
module tb_muldiv_hilo;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] A, B;
  logic [2:0]  Op;
  logic        Start;
  logic [31:0] Hi_out, Lo_out;
  logic        Busy, Done, DivZero;

  muldiv_hilo dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .Op(Op), .Start(Start),
    .Hi_out(Hi_out), .Lo_out(Lo_out), .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 expected no result at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", 64'(Hi_out), 64'(e.hi));
        chk("lo", 64'(Lo_out), 64'(e.lo));
        chk("divzero", 64'(DivZero), 64'(e.dz));
        chk("latency", 64'(cyc - e.acc), 64'd33);
      end
    end
  end

  // Wait (bounded) until the monitor has consumed every expected result.
  task automatic wait_empty();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout: got %0d pending results expected 0", sb.size());
    sb.delete();
  endtask

  // Called between a negedge and the next posedge; that posedge accepts.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.acc = cyc + 1;
    sb.push_back(e);
    A = a; B = b; Op = op; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_empty();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; A = '0; B = '0; Op = 3'd6; Start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_hi", 64'(Hi_out), 64'd0);
    chk("rst_lo", 64'(Lo_out), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_divzero", 64'(DivZero), 64'd0);

    // MULTU 5*7 aborted by reset just after E10
    A = 32'd5; B = 32'd7; Op = 3'd1; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    chk("abort_busy_before", 64'(Busy), 64'd1);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_hi", 64'(Hi_out), 64'd0);
    chk("abort_lo", 64'(Lo_out), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_hi_after", 64'(Hi_out), 64'd0);
    chk("abort_lo_after", 64'(Lo_out), 64'd0);
    #1;

    // Multiplies
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);
    run_op(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0);

    // Divides
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

    // Divide by zero, unsigned then signed (quotient all-ones gets sign-fixed)
    run_op(3'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    chk("dz_done_clear", 64'(Done), 64'd0);
    chk("dz_flag_clear", 64'(DivZero), 64'd0);
    #1;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'd1, 1'b1);

    // Start while busy is dropped, then MTHI right at E34
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'd12; e.dz = 1'b0; e.acc = cyc + 1;
      sb.push_back(e);
    end
    A = 32'd3; B = 32'd4; Op = 3'd1; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (4) @(negedge clk);
    A = 32'd100; B = 32'd7; Op = 3'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    chk("busy_mid", 64'(Busy), 64'd1);
    chk("hold_lo_mid", 64'(Lo_out), 64'hFFFF_FFF9 & 64'h0 | 64'd1);
    wait_empty();
    A = 32'hDEAD_BEEF; Op = 3'd4; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    chk("mthi_hi", 64'(Hi_out), 64'hDEAD_BEEF);
    chk("mthi_lo", 64'(Lo_out), 64'd12);
    chk("mthi_done", 64'(Done), 64'd0);
    chk("mthi_busy", 64'(Busy), 64'd0);

    // MTLO and an ignored no-op
    A = 32'hCAFE_0001; Op = 3'd5; Start = 1'b1;
    @(negedge clk);
    A = 32'h5555_5555; Op = 3'd7;
    @(negedge clk);
    Start = 1'b0;
    chk("mtlo_lo", 64'(Lo_out), 64'hCAFE_0001);
    chk("noop_hi", 64'(Hi_out), 64'hDEAD_BEEF);
    chk("noop_busy", 64'(Busy), 64'd0);
    repeat (40) @(negedge clk);
    chk("pending", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
